spi_sensor_responder: RTL and testbench

//  SPI mode-3 responder (CPOL=1, CPHA=1) for the far end of the dut SPI master port.

---
 rtl/spi_sensor_responder_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_sensor_responder.sv | 187 ++++++++++++++++++
 tb/tb_spi_sensor_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sensor_responder_pkg.sv
// Shared definitions for the SPI sensor responder: command bit positions,
// FSM state encodings and the burst address-advance rule.
package spi_sensor_responder_pkg;

  localparam int unsigned SPI_RW_BIT = 7;
  localparam int unsigned SPI_MS_BIT = 6;
  localparam int unsigned REG_COUNT  = 64;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE = 2'd0;
  localparam spi_state_t ST_CMD  = 2'd1;
  localparam spi_state_t ST_DATA = 2'd2;

  // Multi-byte bursts step the address only when MS is set; 0x3F wraps to 0x00.
  function automatic logic [5:0] next_addr(input logic [5:0] addr, input logic ms);
    return ms ? (addr + 6'd1) : addr;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall
// pulses generated in the system clock domain.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw input through the synchroniser and remember the last synchronised value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_sensor_responder.sv
// SPI mode-3 responder emulating a 64 x 8 register-mapped accelerometer.
// Frame: command byte {RW, MS, ADDR[5:0]} followed by data bytes.
// The fabric can load registers at any time; SPI writes are reported out.
module spi_sensor_responder
  import spi_sensor_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [5:0]  WHOAMI_ADDR = 6'h0F,
  parameter logic [7:0]  WHOAMI_VAL  = 8'h33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       upd_valid,
  input  logic [5:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic w_sck_q, w_sck_rise, w_sck_fall;
  logic w_csn_q, w_csn_rise, w_csn_fall;
  logic w_mosi_q, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (spi_sck),
    .o_q     (w_sck_q),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (spi_csn),
    .o_q     (w_csn_q),
    .o_rise  (w_csn_rise),
    .o_fall  (w_csn_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (spi_mosi),
    .o_q     (w_mosi_q),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  spi_state_t r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic       r_rw;
  logic       r_ms;
  logic [5:0] r_addr;
  logic [7:0] r_tx;
  logic       r_miso;
  logic       r_wr_strobe;
  logic [5:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_regs [REG_COUNT];

  logic       w_sel;
  logic       w_rise;
  logic       w_fall;
  logic [7:0] w_rx_byte;
  logic       w_byte_done;
  logic       w_cmd_done;
  logic       w_data_done;
  logic       w_spi_commit;
  logic [5:0] w_cmd_addr;
  logic [5:0] w_addr_next;
  logic [7:0] w_rd_cmd;
  logic [7:0] w_rd_next;

  // SCK edges only count while selected; a CS edge in the same clock takes priority.
  assign w_sel        = ~w_csn_q;
  assign w_rise       = w_sck_rise & w_sel & ~w_csn_fall;
  assign w_fall       = w_sck_fall & w_sel & ~w_csn_fall;
  assign w_rx_byte    = {r_rx, w_mosi_q};
  assign w_byte_done  = w_rise && (r_bit_cnt == 3'd7) && (r_state != ST_IDLE);
  assign w_cmd_done   = w_byte_done && (r_state == ST_CMD);
  assign w_data_done  = w_byte_done && (r_state == ST_DATA);
  assign w_spi_commit = w_data_done && !r_rw && (r_addr != WHOAMI_ADDR);
  assign w_cmd_addr   = w_rx_byte[5:0];
  assign w_addr_next  = next_addr(r_addr, r_ms);

  // Asynchronous register reads; the identity register is a constant.
  assign w_rd_cmd  = (w_cmd_addr  == WHOAMI_ADDR) ? WHOAMI_VAL : r_regs[w_cmd_addr];
  assign w_rd_next = (w_addr_next == WHOAMI_ADDR) ? WHOAMI_VAL : r_regs[w_addr_next];

  // Frame FSM, bit counter, MOSI shifter and command/address tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_rw      <= 1'b0;
      r_ms      <= 1'b0;
      r_addr    <= '0;
    end else if (w_csn_rise) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
    end else if (w_csn_fall) begin
      r_state   <= ST_CMD;
      r_bit_cnt <= '0;
    end else if (w_rise && (r_state != ST_IDLE)) begin
      r_rx      <= w_rx_byte[6:0];
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_cmd_done) begin
        r_state <= ST_DATA;
        r_rw    <= w_rx_byte[SPI_RW_BIT];
        r_ms    <= w_rx_byte[SPI_MS_BIT];
        r_addr  <= w_cmd_addr;
      end else if (w_data_done) begin
        r_addr  <= w_addr_next;
      end
    end
  end

  // MISO path: read data is captured at the byte boundary and shifted out on SCK falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx   <= '0;
      r_miso <= 1'b1;
    end else if (w_csn_rise || w_csn_fall) begin
      r_miso <= 1'b1;
    end else if (w_cmd_done && w_rx_byte[SPI_RW_BIT]) begin
      r_tx <= w_rd_cmd;
    end else if (w_data_done && r_rw) begin
      r_tx <= w_rd_next;
    end else if (w_fall) begin
      if ((r_state == ST_DATA) && r_rw) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b1};
      end else begin
        r_miso <= 1'b1;
      end
    end
  end

  // Report each completed SPI write byte with a one-clock strobe; address/data hold until the next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_data_done && !r_rw) begin
        r_wr_strobe <= 1'b1;
        r_wr_addr   <= r_addr;
        r_wr_data   <= w_rx_byte;
      end
    end
  end

  // Register file: the fabric load is applied last so it wins a same-clock, same-address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_regs <= '{default: '0};
    end else begin
      if (w_spi_commit) begin
        r_regs[r_addr] <= w_rx_byte;
      end
      if (upd_valid && (upd_addr != WHOAMI_ADDR)) begin
        r_regs[upd_addr] <= upd_data;
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = w_sel;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Self-checking bench for spi_sensor_responder: directed scenarios plus
// randomized register traffic checked against a behavioural register model.
module tb_spi_sensor_responder;

  localparam int HALF = 12;  // clk cycles per SCK half period

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       spi_sck   = 1'b1;
  logic       spi_csn   = 1'b1;
  logic       spi_mosi  = 1'b0;
  logic       upd_valid = 1'b0;
  logic [5:0] upd_addr  = 6'h00;
  logic [7:0] upd_data  = 8'h00;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mregs [64];
  logic [7:0]  txq [$];
  logic [7:0]  rxq [$];
  logic [7:0]  dq  [$];
  logic [13:0] sq  [$];

  always #10 clk = ~clk;

  spi_sensor_responder #(
    .SYNC_STAGES (2),
    .WHOAMI_ADDR (6'h0F),
    .WHOAMI_VAL  (8'h33)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_sck     (spi_sck),
    .spi_csn     (spi_csn),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .upd_valid   (upd_valid),
    .upd_addr    (upd_addr),
    .upd_data    (upd_data),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  // Record every clock in which the write strobe is high.
  always @(negedge clk) begin
    if (wr_strobe) sq.push_back({wr_addr, wr_data});
  end

  initial begin
    #1900000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [5:0] a);
    if (a == 6'h0F) return 8'h33;
    return mregs[a];
  endfunction

  // Master side of mode 3: drive MOSI with SCK falling, sample MISO just before SCK rises.
  task automatic xfer(input logic [7:0] tx, input int nbits, input logic collide,
                      output logic [7:0] rx);
    logic [7:0] t;
    t  = tx;
    rx = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = t[7];
      t        = {t[6:0], 1'b0};
      spi_sck  = 1'b0;
      repeat (HALF) @(negedge clk);
      rx      = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      if (collide && (k == nbits - 1)) begin
        // With two sync stages the byte commits on the third rising clk after this SCK edge.
        repeat (2) @(negedge clk);
        upd_valid = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic frame(input int abort_bits, input logic [7:0] ab_byte, input logic collide);
    logic [7:0] rx;
    rxq = {};
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_in_frame", 32'(busy), 32'd1);
    check("oe_in_frame", 32'(spi_miso_oe), 32'd1);
    for (int b = 0; b < txq.size(); b++) begin
      xfer(txq[b], 8, collide && (b == txq.size() - 1), rx);
      rxq.push_back(rx);
    end
    if (abort_bits > 0) xfer(ab_byte, abort_bits, 1'b0, rx);
    spi_csn = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_after_csn", 32'(busy), 32'd0);
    check("oe_after_csn", 32'(spi_miso_oe), 32'd0);
    check("miso_idle", 32'(spi_miso), 32'd1);
  endtask

  task automatic spi_write(input logic [5:0] addr, input logic ms, input logic collide);
    logic [5:0]  a;
    logic [13:0] e;
    a = addr;
    e = 14'h0;
    txq = {};
    txq.push_back({1'b0, ms, addr});
    foreach (dq[k]) txq.push_back(dq[k]);
    sq.delete();
    frame(0, 8'h00, collide);
    check("wr_count", 32'(sq.size()), 32'(dq.size()));
    for (int k = 0; k < dq.size(); k++) begin
      e = {a, dq[k]};
      if (k < sq.size()) check($sformatf("wr_event%0d", k), 32'(sq[k]), 32'(e));
      check("wr_frame_miso", 32'(rxq[k + 1]), 32'hFF);
      if (a != 6'h0F) mregs[a] = dq[k];
      if (ms) a = a + 6'd1;
    end
    if (collide) mregs[upd_addr] = upd_data;
    if (dq.size() > 0) check("wr_hold", 32'({wr_addr, wr_data}), 32'(e));
  endtask

  task automatic spi_read(input logic [5:0] addr, input logic ms, input int n);
    logic [5:0] a;
    a = addr;
    txq = {};
    txq.push_back({1'b1, ms, addr});
    for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
    sq.delete();
    frame(0, 8'h00, 1'b0);
    check("rd_cmd_miso", 32'(rxq[0]), 32'hFF);
    for (int k = 1; k <= n; k++) begin
      check($sformatf("rd_data@%02h", a), 32'(rxq[k]), 32'(m_rd(a)));
      if (ms) a = a + 6'd1;
    end
    check("rd_no_wr", 32'(sq.size()), 32'd0);
  endtask

  task automatic upd(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    upd_addr  = a;
    upd_data  = d;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    if (a != 6'h0F) mregs[a] = d;
  endtask

  initial begin
    logic [7:0] rx;
    logic [5:0] ra;
    logic       rms;
    int         op;
    int         n;

    mregs = '{default: 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'd1);
    check("rst_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Identity register
    spi_read(6'h0F, 1'b0, 1);

    // Burst write with increment, then read back
    dq = {8'hAA, 8'hBB, 8'hCC};
    spi_write(6'h20, 1'b1, 1'b0);
    spi_read(6'h20, 1'b1, 3);

    // Address wrap and no-increment bursts
    dq = {8'h11};
    spi_write(6'h3F, 1'b0, 1'b0);
    dq = {8'h22};
    spi_write(6'h00, 1'b0, 1'b0);
    spi_read(6'h3F, 1'b1, 2);
    spi_read(6'h3F, 1'b0, 2);

    // Frame aborted mid-byte
    txq = {8'h20};
    sq.delete();
    frame(4, 8'h5C, 1'b0);
    check("abort_no_wr", 32'(sq.size()), 32'd0);
    spi_read(6'h20, 1'b0, 1);

    // Fabric load colliding with an SPI commit to the same register
    upd_addr = 6'h28;
    upd_data = 8'h5A;
    dq = {8'hA5};
    spi_write(6'h28, 1'b0, 1'b1);
    spi_read(6'h28, 1'b0, 1);

    // Writes to the identity register are ignored from both sides
    dq = {8'h77};
    spi_write(6'h0F, 1'b0, 1'b0);
    upd(6'h0F, 8'h99);
    spi_read(6'h0E, 1'b1, 3);

    // Randomized register traffic
    for (int it = 0; it < 10; it++) begin
      op  = int'($urandom_range(0, 2));
      ra  = 6'($urandom);
      rms = 1'($urandom);
      n   = int'($urandom_range(1, 3));
      if (op == 0) begin
        upd(ra, 8'($urandom));
        spi_read(ra, 1'b0, 1);
      end else if (op == 1) begin
        dq = {};
        for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
        spi_write(ra, rms, 1'b0);
      end else begin
        spi_read(ra, rms, n);
      end
    end

    // Reset asserted in the middle of a read burst
    spi_csn = 1'b0;
    repeat (4) @(negedge clk);
    xfer(8'hE0, 8, 1'b0, rx);
    xfer(8'h00, 8, 1'b0, rx);
    xfer(8'h00, 3, 1'b0, rx);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_miso", 32'(spi_miso), 32'd1);
    check("midrst_oe", 32'(spi_miso_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wr_strobe", 32'(wr_strobe), 32'd0);
    spi_csn = 1'b1;
    spi_sck = 1'b1;
    reset_n = 1'b1;
    mregs = '{default: 8'h00};
    repeat (8) @(negedge clk);
    spi_read(6'h20, 1'b1, 3);
    spi_read(6'h27, 1'b1, 2);
    spi_read(6'h0E, 1'b1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
